// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared types and helpers for the UART blocks (receiver, transmitter,
//   flow-control logic).
//   - parity_e : line parity selection (none / even / odd)
//   - state_e  : receiver frame state machine encoding
//   - ticks_per_baud() : oversampling ratio from clock and line rate
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ParityNone = 2'd0,
        ParityEven = 2'd1,
        ParityOdd  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4,
        StBreak  = 3'd5
    } state_e;

    // Smallest oversampling ratio that still leaves a usable mid-bit point
    // and a distinct half-bit point for start-bit validation.
    localparam int unsigned MinTicksPerBaud = 4;

    localparam int unsigned MinDataBits = 5;
    localparam int unsigned MaxDataBits = 9;
    localparam int unsigned MinStopBits = 1;
    localparam int unsigned MaxStopBits = 2;

    function automatic int unsigned ticks_per_baud(input int unsigned clk_hz,
                                                   input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// ----------------------------------------------------------------------------
// sync_ff
//   Multi-flop synchroniser for a single asynchronous input bit.
//   Flops reset to ResetVal so an idle-high line does not look like a
//   falling edge when reset is released.
// Ports
//   clk_i   in  1  destination clock
//   rst_ni  in  1  asynchronous active-low reset
//   d_i     in  1  asynchronous input
//   q_o     out 1  synchronised output (Stages clocks of latency)
// ----------------------------------------------------------------------------
module sync_ff #(
    parameter int unsigned Stages   = 2,
    parameter logic        ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] r_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= {Stages{ResetVal}};
        end else begin
            r_q <= {r_q[Stages-2:0], d_i};
        end
    end

    assign q_o = r_q[Stages-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg
//   Oversampling UART receiver with configurable data width, parity and stop
//   bits. Synchronises the line, rejects short start-bit glitches, checks
//   parity and stop bits, and presents each frame through a one-entry
//   valid/ready buffer. A frame that completes while the buffer is still
//   full is dropped and reported with a one-cycle overrun pulse.
// Ports
//   clk_i            in   1         system clock
//   rst_ni           in   1         asynchronous active-low reset
//   uart_rx_i        in   1         async serial line, idle high
//   rx_data_o        out  DataBits  received word, stable while rx_valid_o
//   rx_valid_o       out  1         word available, held until rx_ready_i
//   rx_ready_i       in   1         consumer accepts on rx_valid_o && rx_ready_i
//   rx_frame_err_o   out  1         a stop bit of this word was sampled low
//   rx_parity_err_o  out  1         parity mismatch on this word
//   rx_overrun_o     out  1         one-cycle pulse: finished frame dropped
//   rx_busy_o        out  1         receiver is inside a frame (not idle)
// ----------------------------------------------------------------------------
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned ClkHz      = 48_000_000,
    parameter int unsigned BaudRate   = 115_200,
    parameter int unsigned DataBits   = 8,
    parameter parity_e     ParityMode = ParityNone,
    parameter int unsigned StopBits   = 1,
    parameter int unsigned SyncStages = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                uart_rx_i,
    output logic [DataBits-1:0] rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                rx_frame_err_o,
    output logic                rx_parity_err_o,
    output logic                rx_overrun_o,
    output logic                rx_busy_o
);

    localparam int unsigned TicksPerBaud = ticks_per_baud(ClkHz, BaudRate);
    localparam int unsigned CntW         = $clog2(TicksPerBaud);
    localparam int unsigned Half         = TicksPerBaud / 2;
    localparam int unsigned IdxW         = $clog2(DataBits + 1);

    localparam logic [CntW-1:0] CntLast  = CntW'(TicksPerBaud - 1);
    localparam logic [CntW-1:0] CntHalf  = CntW'(Half - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(DataBits - 1);
    localparam logic            StopLast = 1'(StopBits - 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (TicksPerBaud < MinTicksPerBaud) begin : g_chk_tpb
        $fatal(1, "uart_rx_cfg: ClkHz/BaudRate must be at least 4");
    end
    if (DataBits < MinDataBits || DataBits > MaxDataBits) begin : g_chk_data
        $fatal(1, "uart_rx_cfg: DataBits must be in 5..9");
    end
    if (StopBits < MinStopBits || StopBits > MaxStopBits) begin : g_chk_stop
        $fatal(1, "uart_rx_cfg: StopBits must be in 1..2");
    end
    if (SyncStages < 2) begin : g_chk_sync
        $fatal(1, "uart_rx_cfg: SyncStages must be at least 2");
    end

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic w_rx_s;

    sync_ff #(
        .Stages   (SyncStages),
        .ResetVal (1'b1)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (uart_rx_i),
        .q_o    (w_rx_s)
    );

    // ------------------------------------------------------------------
    // Frame state and datapath registers
    // ------------------------------------------------------------------
    state_e              r_state;
    state_e              w_state_nxt;
    logic [CntW-1:0]     r_cnt;
    logic [IdxW-1:0]     r_bit_idx;
    logic                r_stop_idx;
    logic [DataBits-1:0] r_shift;
    logic                r_frame_err;
    logic                r_par_err;

    // Output buffer
    logic [DataBits-1:0] r_data;
    logic                r_valid;
    logic                r_buf_ferr;
    logic                r_buf_perr;
    logic                r_overrun;

    // Strobes from the next-state logic
    logic w_tick_half;
    logic w_tick_full;
    logic w_frame_start;
    logic w_cnt_clr;
    logic w_shift_en;
    logic w_par_en;
    logic w_stop_en;
    logic w_done;
    logic w_ferr_final;
    logic w_par_calc;

    assign w_tick_half = (r_cnt == CntHalf);
    assign w_tick_full = (r_cnt == CntLast);

    // Last stop sample is folded in combinationally so the buffered error
    // reflects it in the same cycle the frame completes.
    assign w_ferr_final = r_frame_err | ~w_rx_s;

    // Parity bit joins the data XOR; odd parity expects an overall 1.
    assign w_par_calc = ((^r_shift) ^ w_rx_s) != (ParityMode == ParityOdd);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_cnt_clr     = 1'b0;
        w_shift_en    = 1'b0;
        w_par_en      = 1'b0;
        w_stop_en     = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            StIdle: begin
                if (!w_rx_s) begin
                    w_state_nxt   = StStart;
                    w_frame_start = 1'b1;
                    w_cnt_clr     = 1'b1;
                end
            end

            // Half a bit after the falling edge the line must still be low,
            // otherwise it was a glitch and nothing is reported.
            StStart: begin
                if (w_tick_half) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_rx_s ? StIdle : StData;
                end
            end

            StData: begin
                if (w_tick_full) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == IdxLast) begin
                        w_state_nxt = (ParityMode != ParityNone) ? StParity : StStop;
                    end
                end
            end

            StParity: begin
                if (w_tick_full) begin
                    w_par_en    = 1'b1;
                    w_state_nxt = StStop;
                end
            end

            // A low final stop sample means the line may be in break; wait
            // for it to return high so a held-low line reports only once.
            StStop: begin
                if (w_tick_full) begin
                    w_stop_en = 1'b1;
                    if (r_stop_idx == StopLast) begin
                        w_done      = 1'b1;
                        w_state_nxt = w_rx_s ? StIdle : StBreak;
                    end
                end
            end

            StBreak: begin
                if (w_rx_s) begin
                    w_state_nxt = StIdle;
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Baud counter, bit counters, shift register and error accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_par_err   <= 1'b0;
        end else begin
            if (w_cnt_clr || w_tick_full) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end

            if (w_frame_start) begin
                r_bit_idx   <= '0;
                r_stop_idx  <= 1'b0;
                r_frame_err <= 1'b0;
                r_par_err   <= 1'b0;
            end

            // LSB arrives first; shifting in at the MSB leaves the word
            // aligned after the last data bit.
            if (w_shift_en) begin
                r_shift   <= {w_rx_s, r_shift[DataBits-1:1]};
                r_bit_idx <= r_bit_idx + IdxW'(1);
            end

            if (w_par_en) begin
                r_par_err <= w_par_calc;
            end

            if (w_stop_en) begin
                r_stop_idx <= ~r_stop_idx;
                if (!w_rx_s) begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // One-entry output buffer with overrun detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_buf_ferr <= 1'b0;
            r_buf_perr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                // An accept in this same cycle frees the slot for the new word.
                if (!r_valid || rx_ready_i) begin
                    r_data     <= r_shift;
                    r_buf_ferr <= w_ferr_final;
                    r_buf_perr <= r_par_err;
                    r_valid    <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data_o       = r_data;
    assign rx_valid_o      = r_valid;
    assign rx_frame_err_o  = r_buf_ferr;
    assign rx_parity_err_o = r_buf_perr;
    assign rx_overrun_o    = r_overrun;
    assign rx_busy_o       = (r_state != StIdle);

endmodule
